// File: rtl/heater_sched_pkg.sv
// rtl/heater_sched_pkg.sv - shared state encoding and sizing helpers for the heater scheduler
package heater_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HEAT,
        DRAIN,
        COOL,
        DONE
    } hs_state_e;

    localparam int HS_MAX_N_REQ = 8;

    // Counter must hold the largest preload: dwell-1, FILL-1, DRAIN-1 or COOL-1.
    function automatic int hs_cnt_width(input int dwell_w, input int fill, input int drain,
                                        input int cool);
        int w;
        w = dwell_w;
        if ($clog2(fill + 1) > w)  w = $clog2(fill + 1);
        if ($clog2(drain + 1) > w) w = $clog2(drain + 1);
        if ($clog2(cool + 1) > w)  w = $clog2(cool + 1);
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr, wrapping N-1 to 0
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            int j;
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/heater_scheduler.sv
// rtl/heater_scheduler.sv - round-robin fill/heat/drain sequencer for one shared heater
// Optional cool-down phase after drain: HEATER_SCHED_COOLDOWN_EN
module heater_scheduler
    import heater_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_W      = 16,
    parameter int FILL_CYCLES  = 8,
    parameter int DRAIN_CYCLES = 8,
    parameter int COOL_CYCLES  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DWELL_W-1:0]   dwell,
    output logic [N_REQ-1:0]           grant,
    output logic                       valve_in_en,
    output logic                       heater_en,
    output logic                       valve_out_en,
    output logic [N_REQ-1:0]           done,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = hs_cnt_width(DWELL_W, FILL_CYCLES, DRAIN_CYCLES, COOL_CYCLES);

    hs_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      win_q, win_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic [DWELL_W-1:0] dwell_sel;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign dwell_sel = dwell[arb_idx*DWELL_W +: DWELL_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = FILL;
                    grant_d = arb_gnt;
                    win_d   = arb_idx;
                    // A zero dwell still gets one heater cycle.
                    dwell_d = (dwell_sel == '0) ? DWELL_W'(1) : dwell_sel;
                    cnt_d   = CW'(FILL_CYCLES - 1);
                end
            end
            FILL: begin
                if (cnt_q == '0) begin
                    state_d = HEAT;
                    cnt_d   = CW'(dwell_q) - CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HEAT: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(DRAIN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
`ifdef HEATER_SCHED_COOLDOWN_EN
                    state_d = COOL;
                    cnt_d   = CW'(COOL_CYCLES - 1);
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            COOL: begin
`ifdef HEATER_SCHED_COOLDOWN_EN
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant        = grant_q;
    assign valve_in_en  = (state_q == FILL);
    assign heater_en    = (state_q == HEAT);
    assign valve_out_en = (state_q == DRAIN);
    assign done         = (state_q == DONE) ? grant_q : '0;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_heater_scheduler.sv
// tb/tb_heater_scheduler.sv - randomized and directed bench against a job-timeline reference model
module tb_heater_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int F  = 8;
    localparam int R  = 8;
    localparam int C  = 4;
`ifdef HEATER_SCHED_COOLDOWN_EN
    localparam int CL = C;
`else
    localparam int CL = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] dwell = '0;
    logic [N-1:0]    grant;
    logic            valve_in_en;
    logic            heater_en;
    logic            valve_out_en;
    logic [N-1:0]    done;
    logic            busy;

    heater_scheduler #(
        .N_REQ(N), .DWELL_W(DW), .FILL_CYCLES(F), .DRAIN_CYCLES(R), .COOL_CYCLES(C)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .dwell        (dwell),
        .grant        (grant),
        .valve_in_en  (valve_in_en),
        .heater_en    (heater_en),
        .valve_out_en (valve_out_en),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: one job is a timeline measured from the IDLE cycle that sampled req.
    bit           m_busy = 1'b0;
    int           m_start = 0;
    int           m_win = 0;
    int           m_d = 1;
    int           m_ptr = 0;
    int           cyc = 0;
    int           hcnt = 0;
    int           dcnt1 = 0;
    int           gq[$];
    logic [N-1:0] prev_grant = '0;

    always @(negedge clk) begin
        int k;
        int last;
        int d;
        bit found;
        logic [N-1:0] eg, ed;
        logic ei, eh, eo, eb;
        k = 0; last = 0;
        eg = '0; ed = '0; ei = 1'b0; eh = 1'b0; eo = 1'b0; eb = 1'b0;
        if (m_busy) begin
            k    = cyc - m_start;
            last = F + m_d + R + CL + 1;
            if (k >= 1 && k <= last) begin
                eg = N'(1) << m_win;
                eb = 1'b1;
            end
            ed = (k == last) ? eg : '0;
            ei = (k >= 1) && (k <= F);
            eh = (k > F) && (k <= F + m_d);
            eo = (k > F + m_d) && (k <= F + m_d + R);
        end
        check("grant", 32'(grant), 32'(eg));
        check("done", 32'(done), 32'(ed));
        check("valve_in_en", 32'(valve_in_en), 32'(ei));
        check("heater_en", 32'(heater_en), 32'(eh));
        check("valve_out_en", 32'(valve_out_en), 32'(eo));
        check("busy", 32'(busy), 32'(eb));

        if (heater_en) hcnt++;
        if (done[1]) dcnt1++;
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
        end
        prev_grant = grant;

        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (m_busy) begin
            if (k == last) begin
                m_busy = 1'b0;
                m_ptr  = (m_win + 1) % N;
            end
        end else if (req != '0) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                int j;
                j = (m_ptr + i) % N;
                if (!found && req[j]) begin
                    found = 1'b1;
                    m_win = j;
                end
            end
            d       = int'(dwell[m_win*DW +: DW]);
            m_d     = (d == 0) ? 1 : d;
            m_busy  = 1'b1;
            m_start = cyc;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        step();
        while (busy && n < budget) begin
            step();
            n++;
        end
        if (busy) check("timeout_idle", 32'(busy), 32'(0));
    endtask

    task automatic wait_heater(input int budget);
        int n;
        n = 0;
        while (!heater_en && n < budget) begin
            step();
            n++;
        end
        if (!heater_en) check("timeout_heat", 32'(heater_en), 32'(1));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // single job, dwell 5
        dwell[0 +: DW] = 16'd5;
        req = 4'b0001;
        step();
        req = '0;
        wait_idle(100);

        // round-robin from a freshly reset pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) dwell[i*DW +: DW] = 16'd1;
        gq.delete();
        req = 4'b1111;
        repeat (5) wait_idle(100);
        req = '0;
        repeat (3) step();
        check("rr_count", 32'(gq.size()), 32'(5));
        for (int i = 0; i < 5 && i < gq.size(); i++) check("rr_order", 32'(gq[i]), 32'(i % N));

        // zero dwell still heats one cycle
        dwell[2*DW +: DW] = 16'd0;
        hcnt = 0;
        req = 4'b0100;
        step();
        req = '0;
        wait_idle(100);
        check("zero_dwell_heat", 32'(hcnt), 32'(1));

        // requester drops req during heat
        dwell[1*DW +: DW] = 16'd6;
        dcnt1 = 0;
        req = 4'b0010;
        step();
        wait_heater(50);
        req = '0;
        wait_idle(100);
        step();
        check("drop_done_pulses", 32'(dcnt1), 32'(1));

        // reset mid-heat aborts the job
        dwell[0 +: DW] = 16'd10;
        req = 4'b0001;
        step();
        req = '0;
        wait_heater(50);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        req = 4'b0010;
        step();
        check("post_rst_grant", 32'(grant), 32'(4'b0010));
        req = '0;
        wait_idle(100);

        // randomized traffic with rare resets
        repeat (600) begin
            req = N'($urandom);
            for (int i = 0; i < N; i++) dwell[i*DW +: DW] = DW'($urandom_range(0, 5));
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        req = '0;
        wait_idle(200);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
